// File: rtl/dcb_arb_if.sv
// Flit bus between the router input buffers, the arbitrated crossbar and the output links.
// master = traffic source/sink side, slave = crossbar side.
interface dcb_arb_if #(
    parameter int NN = 2,
    parameter int MN = 3,
    parameter int DW = 8
);
    logic [NN*DW-1:0] i_data;
    logic [NN-1:0]    i_vld;
    logic [NN-1:0]    i_eof;
    logic [NN*MN-1:0] i_dst;
    logic [NN-1:0]    i_rdy;
    logic [MN*DW-1:0] o_data;
    logic [MN-1:0]    o_vld;
    logic [MN-1:0]    o_eof;
    logic [MN-1:0]    o_rdy;
    logic [MN*NN-1:0] cfg;

    modport master (
        output i_data, i_vld, i_eof, i_dst, o_rdy,
        input  i_rdy, o_data, o_vld, o_eof, cfg
    );

    modport slave (
        input  i_data, i_vld, i_eof, i_dst, o_rdy,
        output i_rdy, o_data, o_vld, o_eof, cfg
    );
endinterface

// File: rtl/dcb_arb.sv
// Synchronous NN x MN wormhole crossbar: per-output round-robin grant on head flits,
// connection held until the tail flit is accepted, one registered valid/ready stage per output.
module dcb_arb #(
    parameter int NN = 2,
    parameter int MN = 3,
    parameter int DW = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    dcb_arb_if.slave bus
);
    localparam int IW = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        st      [MN];
    state_t        st_nxt  [MN];
    logic [IW-1:0] own     [MN];
    logic [IW-1:0] own_nxt [MN];
    logic [IW-1:0] ptr     [MN];
    logic [IW-1:0] ptr_nxt [MN];

    logic [DW-1:0]    din     [NN];
    logic [MN-1:0]    dsel    [NN];
    logic [NN-1:0]    req     [MN];
    logic [IW-1:0]    gnt_idx [MN];
    logic [MN-1:0]    gnt;
    logic [NN-1:0]    conn;
    logic [NN-1:0]    rdy;
    logic [MN*NN-1:0] cfg_m;
    logic [MN-1:0]    space;
    logic [MN-1:0]    acc;
    logic [MN-1:0]    rel;

    logic [DW-1:0] data_p1 [MN];
    logic [MN-1:0] vld_p1;
    logic [MN-1:0] eof_p1;

    // Unpack data and reduce each destination to its lowest set bit (malformed multi-hot keeps lowest).
    always_comb begin
        for (int i = 0; i < NN; i++) begin
            din[i]  = bus.i_data[i*DW +: DW];
            dsel[i] = '0;
            for (int j = MN - 1; j >= 0; j--) begin
                if (bus.i_dst[i*MN + j]) begin
                    dsel[i]    = '0;
                    dsel[i][j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cfg_m = '0;
        for (int j = 0; j < MN; j++) begin
            for (int i = 0; i < NN; i++) begin
                cfg_m[j*NN + i] = (st[j] == BUSY) && (own[j] == IW'(i));
            end
        end
    end

    assign space = ~vld_p1 | bus.o_rdy;

    // i_rdy depends only on cfg and o_rdy, never on i_vld.
    always_comb begin
        conn = '0;
        rdy  = '0;
        for (int j = 0; j < MN; j++) begin
            for (int i = 0; i < NN; i++) begin
                conn[i] = conn[i] | cfg_m[j*NN + i];
                rdy[i]  = rdy[i] | (cfg_m[j*NN + i] & space[j]);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < MN; j++) begin
            for (int i = 0; i < NN; i++) begin
                req[j][i] = bus.i_vld[i] & dsel[i][j] & ~conn[i];
            end
        end
    end

    // Round robin: scan ptr+NN down to ptr+1 so the closest candidate after ptr wins last.
    always_comb begin
        logic [IW-1:0] cand;
        cand = '0;
        for (int j = 0; j < MN; j++) begin
            gnt[j]     = 1'b0;
            gnt_idx[j] = '0;
            for (int k = NN; k >= 1; k--) begin
                cand = IW'((int'(ptr[j]) + k) % NN);
                if (req[j][cand]) begin
                    gnt[j]     = 1'b1;
                    gnt_idx[j] = cand;
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < MN; j++) begin
            acc[j] = (st[j] == BUSY) && bus.i_vld[own[j]] && space[j];
            rel[j] = acc[j] && bus.i_eof[own[j]];
        end
    end

    always_comb begin
        for (int j = 0; j < MN; j++) begin
            st_nxt[j]  = st[j];
            own_nxt[j] = own[j];
            ptr_nxt[j] = ptr[j];
            case (st[j])
                IDLE: begin
                    if (gnt[j]) begin
                        st_nxt[j]  = BUSY;
                        own_nxt[j] = gnt_idx[j];
                    end
                end
                BUSY: begin
                    if (rel[j]) begin
                        st_nxt[j]  = IDLE;
                        ptr_nxt[j] = own[j];
                    end
                end
                default: st_nxt[j] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int j = 0; j < MN; j++) begin
                st[j]  <= IDLE;
                own[j] <= '0;
                ptr[j] <= IW'(NN - 1);
            end
        end else begin
            for (int j = 0; j < MN; j++) begin
                st[j]  <= st_nxt[j];
                own[j] <= own_nxt[j];
                ptr[j] <= ptr_nxt[j];
            end
        end
    end

    // Output stage p1: payload only moves on accept, so it holds while o_vld & ~o_rdy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= '0;
            eof_p1 <= '0;
            for (int j = 0; j < MN; j++) begin
                data_p1[j] <= '0;
            end
        end else begin
            for (int j = 0; j < MN; j++) begin
                if (acc[j]) begin
                    data_p1[j] <= din[own[j]];
                    eof_p1[j]  <= bus.i_eof[own[j]];
                    vld_p1[j]  <= 1'b1;
                end else if (bus.o_rdy[j]) begin
                    vld_p1[j]  <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.o_data = '0;
        for (int j = 0; j < MN; j++) begin
            bus.o_data[j*DW +: DW] = data_p1[j];
        end
    end

    assign bus.o_vld = vld_p1;
    assign bus.o_eof = eof_p1;
    assign bus.cfg   = cfg_m;
    assign bus.i_rdy = rdy;
endmodule

// File: tb/tb_dcb_arb.sv
// Directed bench for dcb_arb (NN=2, MN=3, DW=8): per-cycle vector table plus a
// backpressured, bubbled stream checked flit by flit.
module tb_dcb_arb;
    localparam int NN = 2;
    localparam int MN = 3;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;

    dcb_arb_if #(.NN(NN), .MN(MN), .DW(DW)) bus ();

    dcb_arb #(.NN(NN), .MN(MN), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [1:0]  vld;
        logic [1:0]  eof;
        logic [5:0]  dst;
        logic [15:0] data;
        logic [2:0]  ordy;
        logic [5:0]  ecfg;
        logic [2:0]  evld;
        logic [2:0]  eeof;
        logic [23:0] edata;
        logic [1:0]  erdy;
    } vec_t;

    vec_t tbl [$];
    int   tests = 0;
    int   fails = 0;
    int   sent;
    int   got;
    logic in_acc;
    logic out_acc;
    logic [23:0] m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] v, input logic [1:0] e, input logic [5:0] d,
                       input logic [15:0] dat, input logic [2:0] ordy, input logic [5:0] ecfg,
                       input logic [2:0] evld, input logic [2:0] eeof, input logic [23:0] edata,
                       input logic [1:0] erdy);
        vec_t x;
        x.rst_n = r;    x.vld  = v;    x.eof  = e;    x.dst   = d;     x.data = dat;
        x.ordy  = ordy; x.ecfg = ecfg; x.evld = evld; x.eeof  = eeof;  x.edata = edata;
        x.erdy  = erdy;
        tbl.push_back(x);
    endtask

    task automatic drive(input logic r, input logic [1:0] v, input logic [1:0] e, input logic [5:0] d,
                         input logic [15:0] dat, input logic [2:0] ordy);
        rst_n      = r;
        bus.i_vld  = v;
        bus.i_eof  = e;
        bus.i_dst  = d;
        bus.i_data = dat;
        bus.o_rdy  = ordy;
    endtask

    initial begin
        drive(1'b0, 2'b00, 2'b00, 6'b0, 16'h0, 3'b111);
        repeat (2) @(negedge clk);

        // reset held with all inputs valid, then parallel single-flit packets in0->out0, in1->out2
        add(1'b0, 2'b11, 2'b11, 6'b100_001, 16'hB0A0, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b0, 2'b11, 2'b11, 6'b100_001, 16'hB0A0, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b0, 2'b11, 2'b11, 6'b100_001, 16'hB0A0, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b11, 2'b11, 6'b100_001, 16'hB0A0, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b11, 2'b11, 6'b100_001, 16'hB0A0, 3'b111, 6'b100001, 3'b000, 3'b000, 24'h0, 2'b11);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b101, 3'b101, 24'hB000A0, 2'b00);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        // 4-flit packet in0 -> out1
        add(1'b1, 2'b01, 2'b00, 6'b000_010, 16'h0011, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b01, 2'b00, 6'b000_010, 16'h0011, 3'b111, 6'b000100, 3'b000, 3'b000, 24'h0, 2'b01);
        add(1'b1, 2'b01, 2'b00, 6'b000_010, 16'h0012, 3'b111, 6'b000100, 3'b010, 3'b000, 24'h001100, 2'b01);
        add(1'b1, 2'b01, 2'b00, 6'b000_010, 16'h0013, 3'b111, 6'b000100, 3'b010, 3'b000, 24'h001200, 2'b01);
        add(1'b1, 2'b01, 2'b01, 6'b000_010, 16'h0014, 3'b111, 6'b000100, 3'b010, 3'b000, 24'h001300, 2'b01);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b010, 3'b010, 24'h001400, 2'b00);
        add(1'b0, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        // round robin on out0 from a fresh pointer: in0, in1, in0
        add(1'b1, 2'b11, 2'b00, 6'b001_001, 16'h3121, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b11, 2'b00, 6'b001_001, 16'h3121, 3'b111, 6'b000001, 3'b000, 3'b000, 24'h0, 2'b01);
        add(1'b1, 2'b11, 2'b01, 6'b001_001, 16'h3122, 3'b111, 6'b000001, 3'b001, 3'b000, 24'h000021, 2'b01);
        add(1'b1, 2'b11, 2'b00, 6'b001_001, 16'h3123, 3'b111, 6'b000000, 3'b001, 3'b001, 24'h000022, 2'b00);
        add(1'b1, 2'b11, 2'b00, 6'b001_001, 16'h3123, 3'b111, 6'b000010, 3'b000, 3'b000, 24'h0, 2'b10);
        add(1'b1, 2'b11, 2'b10, 6'b001_001, 16'h3223, 3'b111, 6'b000010, 3'b001, 3'b000, 24'h000031, 2'b10);
        add(1'b1, 2'b01, 2'b00, 6'b000_001, 16'h0023, 3'b111, 6'b000000, 3'b001, 3'b001, 24'h000032, 2'b00);
        add(1'b1, 2'b01, 2'b00, 6'b000_001, 16'h0023, 3'b111, 6'b000001, 3'b000, 3'b000, 24'h0, 2'b01);
        add(1'b1, 2'b01, 2'b01, 6'b000_001, 16'h0024, 3'b111, 6'b000001, 3'b001, 3'b000, 24'h000023, 2'b01);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b001, 3'b001, 24'h000024, 2'b00);
        // in1 -> out2 with o_rdy[2] low for four cycles
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4100, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4100, 3'b111, 6'b100000, 3'b000, 3'b000, 24'h0, 2'b10);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4200, 3'b111, 6'b100000, 3'b100, 3'b000, 24'h410000, 2'b10);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4300, 3'b011, 6'b100000, 3'b100, 3'b000, 24'h420000, 2'b00);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4300, 3'b011, 6'b100000, 3'b100, 3'b000, 24'h420000, 2'b00);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4300, 3'b011, 6'b100000, 3'b100, 3'b000, 24'h420000, 2'b00);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4300, 3'b011, 6'b100000, 3'b100, 3'b000, 24'h420000, 2'b00);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h4300, 3'b111, 6'b100000, 3'b100, 3'b000, 24'h420000, 2'b10);
        add(1'b1, 2'b10, 2'b10, 6'b100_000, 16'h4400, 3'b111, 6'b100000, 3'b100, 3'b000, 24'h430000, 2'b10);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b100, 3'b100, 24'h440000, 2'b00);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        // multi-hot dst 110 selects out1; dst 000 never requests
        add(1'b1, 2'b11, 2'b11, 6'b000_110, 16'h5150, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b11, 2'b11, 6'b000_110, 16'h5150, 3'b111, 6'b000100, 3'b000, 3'b000, 24'h0, 2'b01);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b010, 3'b010, 24'h005000, 2'b00);
        // reset while out2 is connected and stalled, then a fresh single-flit packet
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h6100, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b10, 2'b00, 6'b100_000, 16'h6100, 3'b111, 6'b100000, 3'b000, 3'b000, 24'h0, 2'b10);
        add(1'b0, 2'b10, 2'b00, 6'b100_000, 16'h6200, 3'b011, 6'b100000, 3'b100, 3'b000, 24'h610000, 2'b00);
        add(1'b1, 2'b10, 2'b10, 6'b100_000, 16'h6300, 3'b111, 6'b000000, 3'b000, 3'b000, 24'h0, 2'b00);
        add(1'b1, 2'b10, 2'b10, 6'b100_000, 16'h6300, 3'b111, 6'b100000, 3'b000, 3'b000, 24'h0, 2'b10);
        add(1'b1, 2'b00, 2'b00, 6'b000_000, 16'h0000, 3'b111, 6'b000000, 3'b100, 3'b100, 24'h630000, 2'b00);

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(tbl[k].rst_n, tbl[k].vld, tbl[k].eof, tbl[k].dst, tbl[k].data, tbl[k].ordy);
            #1;
            m = {{8{tbl[k].evld[2]}}, {8{tbl[k].evld[1]}}, {8{tbl[k].evld[0]}}};
            check($sformatf("v%0d cfg", k),    32'(bus.cfg),            32'(tbl[k].ecfg));
            check($sformatf("v%0d o_vld", k),  32'(bus.o_vld),          32'(tbl[k].evld));
            check($sformatf("v%0d o_eof", k),  32'(bus.o_eof & tbl[k].evld), 32'(tbl[k].eeof));
            check($sformatf("v%0d o_data", k), 32'(bus.o_data & m),     32'(tbl[k].edata & m));
            check($sformatf("v%0d i_rdy", k),  32'(bus.i_rdy),          32'(tbl[k].erdy));
        end

        // 6-flit packet in0 -> out0 with input bubbles and random-looking output stalls
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
            @(negedge clk);
            drive(1'b1, {1'b0, (sent < 6) && (cyc % 3 != 1)}, {1'b0, sent == 5}, 6'b000_001,
                  {8'h00, 8'(8'h70 + sent)}, {2'b11, cyc % 4 != 2});
            #1;
            in_acc  = bus.i_vld[0] & bus.i_rdy[0];
            out_acc = bus.o_vld[0] & bus.o_rdy[0];
            if (out_acc) begin
                check($sformatf("stream flit%0d data", got), 32'(bus.o_data[7:0]), 32'(8'h70 + got));
                check($sformatf("stream flit%0d eof", got),  32'(bus.o_eof[0]),    32'(got == 5));
                got++;
            end
            if (in_acc) sent++;
        end
        check("stream flit count", 32'(got), 32'(6));
        @(negedge clk);
        #1;
        check("stream released cfg", 32'(bus.cfg),   32'(0));
        check("stream drained o_vld", 32'(bus.o_vld), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
